// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, prefetch entry layout
// and PC helpers.
package fetch_pkg;

   localparam int          INST_W  = 32;
   localparam int          PC_W    = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_WAIT = 2'd1,
      F_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch_entry_t words. Flush has priority over push and pop;
// a pop on an empty queue is ignored.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;

   assign pop_ok = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word request at a time to instruction
// memory and queues tagged responses for decode. Redirect flushes and restarts.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [31:0]            imem_addr,
   input  logic                   imem_ack,
   input  logic [31:0]            imem_rdata,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic                   inst_valid,
   output logic [31:0]            inst,
   output logic [31:0]            inst_pc,
   input  logic                   inst_ready,
   output fetch_state_t           dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
);

   // Handshakes: imem_req stays high with imem_addr stable until a cycle where
   // imem_ack is high; decode takes the head on any cycle with inst_valid && inst_ready.

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic          push;
   logic          pop_fire;
   logic          room_after_push;
   logic [31:0]   new_pc;
   logic [31:0]   next_pc;

   assign pop_fire        = inst_valid && inst_ready;
   assign push            = (state == F_WAIT) && imem_ack && !redirect;
   assign push_entry      = '{pc: fetch_pc, inst: imem_rdata};
   assign room_after_push = pop_fire || (count < CW'(DEPTH - 1));
   assign new_pc          = align_pc(redirect_pc);
   assign next_pc         = fetch_pc + PC_STEP;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop_fire),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= F_IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         case (state)
            F_IDLE: begin
               if (redirect) begin
                  fetch_pc <= new_pc;
               end else if (count < CW'(DEPTH)) begin
                  state     <= F_WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            F_WAIT: begin
               if (redirect) begin
                  fetch_pc <= new_pc;
                  if (imem_ack) begin
                     state    <= F_IDLE;
                     imem_req <= 1'b0;
                  end else begin
                     state <= F_DROP;
                  end
               end else if (imem_ack) begin
                  fetch_pc  <= next_pc;
                  imem_addr <= next_pc;
                  if (!room_after_push) begin
                     state    <= F_IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            F_DROP: begin
               // The outstanding word belongs to a squashed path; only the newest target matters.
               if (redirect) fetch_pc <= new_pc;
               if (imem_ack) begin
                  state    <= F_IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= F_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign inst_valid = (count != '0);
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign dbg_state  = state;
   assign dbg_count  = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all scored
// against a queue-based model of the fetched instruction stream.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   imem_req;
   logic [31:0]            imem_addr;
   logic                   imem_ack;
   logic [31:0]            imem_rdata;
   logic                   redirect;
   logic [31:0]            redirect_pc;
   logic                   inst_valid;
   logic [31:0]            inst;
   logic [31:0]            inst_pc;
   logic                   inst_ready;
   fetch_state_t           dbg_state;
   logic [$clog2(DEPTH):0] dbg_count;

   int checks = 0;
   int errors = 0;

   // model: queue of {pc, word} decode should see, next PC to fetch, and
   // whether the outstanding request was squashed by a redirect
   logic [63:0] exp_q[$];
   logic [31:0] model_pc;
   bit          dropped;
   bit          prev_wait;
   logic [31:0] prev_addr;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .dbg_state   (dbg_state),
      .dbg_count   (dbg_count)
   );

   // Scores the cycle about to be clocked, then advances the model.
   task automatic monitor();
      if (!reset) begin
         exp_q.delete();
         model_pc  = RESET_PC;
         dropped   = 0;
         prev_wait = 0;
         return;
      end
      checks++;
      if (inst_valid !== (exp_q.size() != 0)) begin
         errors++;
         $display("FAIL mon_valid: inst_valid=%b expected queue size=%0d", inst_valid, exp_q.size());
      end
      if (exp_q.size() != 0) begin
         checks++;
         if ({inst_pc, inst} !== exp_q[0]) begin
            errors++;
            $display("FAIL mon_head: got pc=%h inst=%h expected pc=%h inst=%h",
                     inst_pc, inst, exp_q[0][63:32], exp_q[0][31:0]);
         end
      end
      checks++;
      if (int'(dbg_count) !== exp_q.size()) begin
         errors++;
         $display("FAIL mon_count: got %0d expected %0d", dbg_count, exp_q.size());
      end
      if (imem_req && !dropped) begin
         checks++;
         if (imem_addr !== model_pc) begin
            errors++;
            $display("FAIL mon_addr: got %h expected %h", imem_addr, model_pc);
         end
      end
      if (prev_wait && imem_req) begin
         checks++;
         if (imem_addr !== prev_addr) begin
            errors++;
            $display("FAIL mon_addr_stable: got %h expected %h", imem_addr, prev_addr);
         end
      end
      checks++;
      if (imem_addr[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL mon_addr_align: got %h expected low bits 00", imem_addr);
      end
      if (inst_valid && inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (redirect) begin
         exp_q.delete();
         model_pc = {redirect_pc[31:2], 2'b00};
         if (imem_req && !imem_ack) dropped = 1;
         else if (imem_req && imem_ack) dropped = 0;
      end else if (imem_req && imem_ack) begin
         if (dropped) begin
            dropped = 0;
         end else begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
            checks++;
            if (exp_q.size() > DEPTH) begin
               errors++;
               $display("FAIL mon_overflow: queue size %0d expected at most %0d", exp_q.size(), DEPTH);
            end
         end
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      imem_ack    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_addr(input logic [31:0] a);
      for (int i = 0; i < 20 && !(imem_req && imem_addr == a); i++) tick();
      checks++;
      if (!(imem_req && imem_addr == a)) begin
         errors++;
         $display("FAIL wait_addr: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      #1;
      tick();
      tick();
      checks++;
      if ({imem_req, inst_valid} !== 2'b00 || imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_outputs: req=%b valid=%b addr=%h expected 0 0 %h", imem_req, inst_valid, imem_addr, RESET_PC);
      end
      checks++;
      if (inst !== 32'h0 || inst_pc !== 32'h0 || dbg_count !== '0 || dbg_state !== F_IDLE) begin
         errors++;
         $display("FAIL reset_state: inst=%h pc=%h count=%0d state=%0d expected zeros/F_IDLE", inst, inst_pc, dbg_count, dbg_state);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_first_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      imem_ack = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stream_rate: cyc %0d valid=%b pc=%h req=%b expected 1 %h 1", i, inst_valid, inst_pc, imem_req, 32'(4 * i));
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b0;
      for (int i = 0; i < 20 && dbg_count != 3'(DEPTH); i++) tick();
      tick();
      tick();
      checks++;
      if (inst_valid !== 1'b1 || int'(dbg_count) !== DEPTH || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL full_stop: valid=%b count=%0d req=%b expected 1 %0d 0", inst_valid, dbg_count, imem_req, DEPTH);
      end
      checks++;
      if (inst_pc !== 32'h0 || inst !== mem_word(32'h0) || dbg_state !== F_IDLE) begin
         errors++;
         $display("FAIL full_head: pc=%h inst=%h state=%0d expected 0 %h F_IDLE", inst_pc, inst, dbg_state, mem_word(32'h0));
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
         errors++;
         $display("FAIL full_resume: req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
   endtask

   task automatic test_delay();
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b1;
      wait_addr(32'd8);
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            errors++;
            $display("FAIL delay_hold: cyc %0d req=%b addr=%h expected 1 00000008", i, imem_req, imem_addr);
         end
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd8 || inst !== mem_word(32'd8)) begin
         errors++;
         $display("FAIL delay_push: valid=%b pc=%h inst=%h expected 1 00000008 %h", inst_valid, inst_pc, inst, mem_word(32'd8));
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b1;
      wait_addr(32'd8);
      imem_ack = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd8 || dbg_state !== F_DROP) begin
         errors++;
         $display("FAIL redir_drop: valid=%b req=%b addr=%h state=%0d expected 0 1 00000008 F_DROP", inst_valid, imem_req, imem_addr, dbg_state);
      end
      tick();
      imem_ack = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_discard: req=%b valid=%b expected 0 0", imem_req, inst_valid);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL redir_restart: req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (inst_valid && inst_pc == 32'd8) begin
            errors++;
            $display("FAIL redir_stale: head pc=%h expected not 00000008", inst_pc);
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_redirect_ack();
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b1;
      wait_addr(32'd8);
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect = 1'b0; imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redack_drop: req=%b valid=%b expected 0 0", imem_req, inst_valid);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++;
         $display("FAIL redack_addr: req=%b addr=%h expected 1 00000200", imem_req, imem_addr);
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
         errors++;
         $display("FAIL redack_push: valid=%b pc=%h expected 1 00000200", inst_valid, inst_pc);
      end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      inst_ready = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
      tick();
      redirect = 1'b0; imem_ack = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_top: req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (imem_addr !== 32'h0 || inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_next: addr=%h valid=%b pc=%h expected 0 1 fffffffc", imem_addr, inst_valid, inst_pc);
      end
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || dbg_state !== F_IDLE) begin
         errors++;
         $display("FAIL async_reset: req=%b valid=%b state=%0d expected 0 0 F_IDLE", imem_req, inst_valid, dbg_state);
      end
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         imem_ack    = ($urandom_range(0, 3) != 0);
         inst_ready  = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
         tick();
      end
      redirect = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_delay();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
